// File: rtl/brew_sequencer.sv
// Brew sequencer: runs cup-drop / heat / pour for each queued dispense order,
// keeps up to three pending orders and latches sensor faults until cleared.
module brew_sequencer #(
  parameter int CUP_CYCLES  = 4,
  parameter int HEAT_CYCLES = 8,
  parameter int POUR_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coff_out,
  input  logic       cup_ok,
  input  logic       water_hot,
  input  logic       fault_clr,
  output logic       cup_drop,
  output logic       heater_on,
  output logic       pump_on,
  output logic       done,
  output logic       busy,
  output logic       fault,
  output logic [1:0] pending,
  output logic       order_full,
  output logic       order_lost
);

  typedef enum logic [2:0] {IDLE, CUP, HEAT, POUR, DONE, FAULT} state_t;

  localparam logic [7:0] CUP_LAST  = 8'(CUP_CYCLES - 1);
  localparam logic [7:0] HEAT_LAST = 8'(HEAT_CYCLES - 1);
  localparam logic [7:0] POUR_LAST = 8'(POUR_CYCLES - 1);

  state_t     state, next;
  logic [7:0] timer;
  logic       leave_done, take, lost;
  logic [1:0] pending_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (pending != 2'd0 || coff_out) next = CUP;
      CUP:   if (timer == CUP_LAST) next = cup_ok ? HEAT : FAULT;
      // water_hot beats the timeout when both land in the same cycle
      HEAT:  if (water_hot) next = POUR;
             else if (timer == HEAT_LAST) next = FAULT;
      POUR:  if (!cup_ok) next = FAULT;
             else if (timer == POUR_LAST) next = DONE;
      DONE:  next = IDLE;
      FAULT: if (fault_clr) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          timer <= 8'd0;
    else if (next != state)                             timer <= 8'd0;
    else if (state == CUP || state == HEAT || state == POUR) timer <= timer + 8'd1;
  end

  // A DONE in the same cycle frees a slot, so a full queue still accepts.
  always_comb begin
    leave_done   = (state == DONE);
    take         = coff_out && (state != FAULT) && (pending != 2'd3 || leave_done);
    lost         = coff_out && !take;
    pending_next = pending;
    if (next == FAULT && state != FAULT) pending_next = 2'd0;
    else if (take && !leave_done)        pending_next = pending + 2'd1;
    else if (!take && leave_done)        pending_next = pending - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= 2'd0;
      order_lost <= 1'b0;
    end else begin
      pending    <= pending_next;
      order_lost <= lost;
    end
  end

  assign cup_drop   = (state == CUP);
  assign heater_on  = (state == HEAT) || (state == POUR);
  assign pump_on    = (state == POUR);
  assign done       = (state == DONE);
  assign fault      = (state == FAULT);
  assign busy       = (state != IDLE);
  assign order_full = (pending == 2'd3);

endmodule
